// File: rtl/glove_cmd_rx.sv
//==============================================================================
// glove_cmd_rx : 8N1 UART receiver and command decoder for the glove link.
//                Keeps a saturating cursor position and emits command pulses.
// Revision: 1.0
//==============================================================================
`default_nettype none

module glove_cmd_rx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int STEP     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       cts,
   output logic [9:0] cursor_x,
   output logic [9:0] cursor_y,
   output logic       click,
   output logic       scroll_up,
   output logic       scroll_down,
   output logic       cmd_valid,
   output logic [3:0] cmd,
   output logic [7:0] err_cnt
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int TW   = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [TW-1:0]      c_DIV_M1  = TW'(DIV - 1);
   localparam logic [TW-1:0]      c_HALF_M1 = TW'(HALF - 1);
   localparam logic signed [10:0] c_STEP    = 11'(STEP);
   localparam logic signed [10:0] c_W       = 11'(SCREEN_W);
   localparam logic signed [10:0] c_H       = 11'(SCREEN_H);
   localparam logic [9:0]         c_X_MAX   = 10'(SCREEN_W - 1);
   localparam logic [9:0]         c_Y_MAX   = 10'(SCREEN_H - 1);
   localparam logic [9:0]         c_X0      = 10'(SCREEN_W / 2);
   localparam logic [9:0]         c_Y0      = 10'(SCREEN_H / 2);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   logic          rx_meta_q, rx_sync_q;
   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          byte_valid_q, frame_err_q;

   logic [9:0] cursor_x_q, cursor_y_q;
   logic       click_q, scroll_up_q, scroll_down_q, cmd_valid_q;
   logic [3:0] cmd_q;
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               timer_q <= '0;
               if (!rx_sync_q) state_q <= S_START;
            end
            S_START: begin
               if (timer_q == c_HALF_M1) begin
                  timer_q   <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rx_sync_q ? S_IDLE : S_DATA;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_DATA: begin
               if (timer_q == c_DIV_M1) begin
                  timer_q   <= '0;
                  shift_q   <= {rx_sync_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) state_q <= S_STOP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_STOP: begin
               if (timer_q == c_DIV_M1) begin
                  timer_q <= '0;
                  if (rx_sync_q) begin
                     byte_valid_q <= 1'b1;
                     state_q      <= S_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_WAIT_IDLE;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               timer_q <= '0;
               if (rx_sync_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Cursor arithmetic is done one bit wider and signed so underflow is visible.
   logic signed [10:0] x_s, y_s, x_dn, x_up, y_dn, y_up;
   logic [9:0]         cursor_x_d, cursor_y_d;
   logic               known_w;

   assign x_s  = signed'({1'b0, cursor_x_q});
   assign y_s  = signed'({1'b0, cursor_y_q});
   assign x_dn = x_s - c_STEP;
   assign x_up = x_s + c_STEP;
   assign y_dn = y_s - c_STEP;
   assign y_up = y_s + c_STEP;

   always_comb begin
      cursor_x_d = cursor_x_q;
      cursor_y_d = cursor_y_q;
      known_w    = 1'b1;
      case (shift_q)
         8'd0: cursor_y_d = (y_dn < 11'sd0) ? 10'd0 : y_dn[9:0];
         8'd1: cursor_y_d = (y_up >= c_H) ? c_Y_MAX : y_up[9:0];
         8'd2: cursor_x_d = (x_dn < 11'sd0) ? 10'd0 : x_dn[9:0];
         8'd3: cursor_x_d = (x_up >= c_W) ? c_X_MAX : x_up[9:0];
         8'd4, 8'd6, 8'd7: ;
         8'd8: begin
            cursor_x_d = c_X0;
            cursor_y_d = c_Y0;
         end
         default: known_w = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cursor_x_q    <= c_X0;
         cursor_y_q    <= c_Y0;
         click_q       <= 1'b0;
         scroll_up_q   <= 1'b0;
         scroll_down_q <= 1'b0;
         cmd_valid_q   <= 1'b0;
         cmd_q         <= '0;
         err_cnt_q     <= '0;
      end else begin
         click_q       <= 1'b0;
         scroll_up_q   <= 1'b0;
         scroll_down_q <= 1'b0;
         cmd_valid_q   <= 1'b0;
         if (byte_valid_q && known_w) begin
            cmd_valid_q   <= 1'b1;
            cmd_q         <= shift_q[3:0];
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
            click_q       <= (shift_q == 8'd4);
            scroll_up_q   <= (shift_q == 8'd6);
            scroll_down_q <= (shift_q == 8'd7);
         end
         if (((byte_valid_q && !known_w) || frame_err_q) && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign cts         = 1'b0;
   assign cursor_x    = cursor_x_q;
   assign cursor_y    = cursor_y_q;
   assign click       = click_q;
   assign scroll_up   = scroll_up_q;
   assign scroll_down = scroll_down_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd         = cmd_q;
   assign err_cnt     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_glove_cmd_rx.sv
//==============================================================================
// tb_glove_cmd_rx : serial-frame driver with a behavioural cursor/command model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_glove_cmd_rx;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int W        = 640;
   localparam int H        = 480;
   localparam int STEP     = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic       cts;
   logic [9:0] cursor_x, cursor_y;
   logic       click, scroll_up, scroll_down, cmd_valid;
   logic [3:0] cmd;
   logic [7:0] err_cnt;

   glove_cmd_rx #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCREEN_W(W), .SCREEN_H(H), .STEP(STEP)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx), .cts(cts),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .click(click), .scroll_up(scroll_up), .scroll_down(scroll_down),
      .cmd_valid(cmd_valid), .cmd(cmd), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: what the outputs must be once the current frame has settled.
   int mx = W / 2, my = H / 2, merr = 0, mcmd = 0;
   int exp_cmd  = 0;
   int issued   = 0;
   int seen     = 0;
   bit settled  = 1'b0;
   bit mon_on   = 1'b0;
   int pulse_hist[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int sat_err(input int e);
      return (e < 255) ? e + 1 : 255;
   endfunction

   function automatic void model_apply(input logic [7:0] b);
      case (b)
         8'd0: my = (my - STEP < 0) ? 0 : my - STEP;
         8'd1: my = (my + STEP >= H) ? H - 1 : my + STEP;
         8'd2: mx = (mx - STEP < 0) ? 0 : mx - STEP;
         8'd3: mx = (mx + STEP >= W) ? W - 1 : mx + STEP;
         8'd8: begin mx = W / 2; my = H / 2; end
         default: ;
      endcase
      if (b <= 8 && b != 5) begin
         mcmd    = int'(b);
         exp_cmd = int'(b);
         issued++;
      end else begin
         merr = sat_err(merr);
      end
   endfunction

   // extra_low: cycles the line stays low after a zero stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(DIV);
      end
      settled = 1'b0;
      rx = stop_bit;
      if (stop_bit) model_apply(b);
      else merr = sat_err(merr);
      tick(DIV);
      chk("cmd_valid_count", seen, issued);
      settled = 1'b1;
      if (!stop_bit) begin
         tick(extra_low);
         rx = 1'b1;
         tick(2);
      end
   endtask

   task automatic do_reset();
      mon_on = 1'b0;
      rx  = 1'b1;
      rst = 1'b0;
      tick(3);
      chk("rst_cursor_x", int'(cursor_x), 320);
      chk("rst_cursor_y", int'(cursor_y), 240);
      chk("rst_pulses", int'({click, scroll_up, scroll_down, cmd_valid}), 0);
      chk("rst_cmd", int'(cmd), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_cts", int'(cts), 0);
      mx = W / 2; my = H / 2; merr = 0; mcmd = 0;
      settled = 1'b1;
      rst = 1'b1;
      tick(2);
      mon_on = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         chk("cts", int'(cts), 0);
         if (cmd_valid) begin
            if (seen == issued) begin
               chk("unexpected_cmd_valid", 1, 0);
            end else begin
               seen++;
               chk("pulse_cmd", int'(cmd), exp_cmd);
               chk("pulse_click", int'(click), int'(exp_cmd == 4));
               chk("pulse_scroll_up", int'(scroll_up), int'(exp_cmd == 6));
               chk("pulse_scroll_down", int'(scroll_down), int'(exp_cmd == 7));
               chk("pulse_cursor_x", int'(cursor_x), mx);
               chk("pulse_cursor_y", int'(cursor_y), my);
            end
         end else begin
            chk("stray_pulse", int'({click, scroll_up, scroll_down}), 0);
         end
         if (click)       pulse_hist.push_back(1);
         if (scroll_up)   pulse_hist.push_back(2);
         if (scroll_down) pulse_hist.push_back(3);
         if (settled) begin
            chk("cursor_x", int'(cursor_x), mx);
            chk("cursor_y", int'(cursor_y), my);
            chk("cmd", int'(cmd), mcmd);
            chk("err_cnt", int'(err_cnt), merr);
         end
      end
   end

   initial begin
      int base;
      int seen0;
      logic [7:0] b;

      tick(2);
      do_reset();

      // Partial frame interrupted by reset must leave no trace.
      rx = 1'b0; tick(DIV);
      rx = 1'b1; tick(DIV);
      rx = 1'b0; tick(2 * DIV);
      do_reset();
      tick(20);

      send_frame(8'h03, 1'b1, 0);
      chk("right_x", int'(cursor_x), 324);
      chk("right_cmd", int'(cmd), 3);

      for (int i = 0; i < 81; i++) send_frame(8'h02, 1'b1, 0);
      chk("left_sat_x", int'(cursor_x), 0);
      for (int i = 0; i < 2; i++) send_frame(8'h02, 1'b1, 0);
      chk("left_stay_x", int'(cursor_x), 0);
      send_frame(8'h08, 1'b1, 0);
      chk("home_x", int'(cursor_x), 320);
      chk("home_y", int'(cursor_y), 240);

      for (int i = 0; i < 60; i++) send_frame(8'h01, 1'b1, 0);
      chk("down_sat_y", int'(cursor_y), 479);
      base = pulse_hist.size();
      send_frame(8'h04, 1'b1, 0);
      send_frame(8'h06, 1'b1, 0);
      send_frame(8'h07, 1'b1, 0);
      chk("pulse_count", pulse_hist.size() - base, 3);
      if (pulse_hist.size() - base == 3) begin
         chk("pulse_order0", pulse_hist[base], 1);
         chk("pulse_order1", pulse_hist[base + 1], 2);
         chk("pulse_order2", pulse_hist[base + 2], 3);
      end

      send_frame(8'h03, 1'b0, 2 * DIV);
      rx = 1'b1; tick(DIV);
      send_frame(8'h00, 1'b1, 0);
      chk("frame_err_cnt", int'(err_cnt), 1);
      chk("frame_err_x", int'(cursor_x), 320);
      chk("frame_err_y", int'(cursor_y), 475);

      for (int i = 0; i < 60; i++) begin
         b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8));
         if ($urandom_range(0, 9) == 0) begin
            send_frame(b, 1'b0, $urandom_range(0, DIV));
         end else begin
            send_frame(b, 1'b1, 0);
            if ($urandom_range(0, 2) != 0) tick($urandom_range(1, 30));
         end
      end

      do_reset();
      seen0 = seen;
      rx = 1'b0; tick(4);
      rx = 1'b1; tick(3 * DIV);
      chk("glitch_err", int'(err_cnt), 0);
      chk("glitch_cmds", seen - seen0, 0);
      send_frame(8'h05, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      chk("unknown_err", int'(err_cnt), 2);
      chk("unknown_cmds", seen - seen0, 0);
      for (int i = 0; i < 256; i++) send_frame(8'($urandom_range(9, 255)), 1'b1, 0);
      chk("err_saturate", int'(err_cnt), 255);
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
